extend_unit_pipe: RTL and testbench

//  Parametrised, buffered extender for the datapath. Each accepted request is an IN_W-bit immediate or

---
 rtl/extend_unit_pipe_pkg.sv | 18 +
 rtl/extend_unit_pipe_core.sv | 41 ++++
 rtl/extend_unit_pipe.sv | 79 +++++++
 tb/tb_extend_unit_pipe.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/extend_unit_pipe_pkg.sv
// Shared mode encoding for the extend unit and its buffered wrapper.
`timescale 1ns/1ps
package extend_unit_pipe_pkg;

   localparam int unsigned ext_mode_w = 3;

   typedef enum logic [ext_mode_w-1:0] {
      ext_sext = 3'd0,
      ext_zext = 3'd1,
      ext_lui  = 3'd2,
      ext_bro  = 3'd3,
      ext_lb   = 3'd4,
      ext_lbu  = 3'd5,
      ext_lh   = 3'd6,
      ext_lhu  = 3'd7
   } ext_mode_e;

endpackage

// File: rtl/extend_unit_pipe_core.sv
// Pure combinational extender: raw immediate / load data plus mode -> OUT_W-bit result.
`timescale 1ns/1ps
module extend_core
   import extend_unit_pipe_pkg::*;
#(
   parameter int unsigned IN_W  = 16,
   parameter int unsigned OUT_W = 32
) (
   input  logic [ext_mode_w-1:0] in_mode,
   input  logic [IN_W-1:0]       in_data,
   output logic [OUT_W-1:0]      result
);

   // Narrow inputs cannot carry a halfword, so LH/LHU fall back to byte behaviour.
   localparam int unsigned HW = (IN_W >= 16) ? 16 : 8;

   logic [OUT_W-1:0] sext, zext, bsext, bzext, hsext, hzext;

   assign sext  = OUT_W'($signed(in_data));
   assign zext  = OUT_W'(in_data);
   assign bsext = OUT_W'($signed(in_data[7:0]));
   assign bzext = OUT_W'(in_data[7:0]);
   assign hsext = OUT_W'($signed(in_data[HW-1:0]));
   assign hzext = OUT_W'(in_data[HW-1:0]);

   always_comb begin
      result = '0;
      unique case (ext_mode_e'(in_mode))
         ext_sext: result = sext;
         ext_zext: result = zext;
         ext_lui:  result = zext << (OUT_W - IN_W);
         ext_bro:  result = sext << 2;
         ext_lb:   result = bsext;
         ext_lbu:  result = bzext;
         ext_lh:   result = hsext;
         ext_lhu:  result = hzext;
         default:  result = '0;
      endcase
   end

endmodule

// File: rtl/extend_unit_pipe.sv
// Buffered extender: extends accepted requests and queues {mode, result} in a DEPTH-entry FIFO.
`timescale 1ns/1ps
module extend_unit_pipe
   import extend_unit_pipe_pkg::*;
#(
   parameter int unsigned IN_W  = 16,
   parameter int unsigned OUT_W = 32,
   parameter int unsigned DEPTH = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [ext_mode_w-1:0]      in_mode,
   input  logic [IN_W-1:0]            in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [OUT_W-1:0]           out_data,
   output logic [ext_mode_w-1:0]      out_mode,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam int unsigned EW = ext_mode_w + OUT_W;

   if (IN_W < 8 || OUT_W < IN_W || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_params
      $error("extend_unit_pipe: illegal IN_W/OUT_W/DEPTH combination");
   end

   logic [OUT_W-1:0] ext_result;
   logic [EW-1:0]    mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             push, pop;

   extend_core #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W)
   ) u_core (
      .in_mode (in_mode),
      .in_data (in_data),
      .result  (ext_result)
   );

   assign in_ready  = !reset && (count_q < CW'(DEPTH));
   assign out_valid = (count_q != '0);
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign count     = count_q;

   // Popped slots are zeroed so an empty queue presents 0 rather than stale data.
   assign out_data  = mem_q[rd_ptr_q][OUT_W-1:0];
   assign out_mode  = mem_q[rd_ptr_q][EW-1:OUT_W];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         // Write and read slots never coincide: push is blocked when full, pop when empty.
         if (pop) begin
            mem_q[rd_ptr_q] <= '0;
            rd_ptr_q        <= rd_ptr_q + 1'b1;
         end
         if (push) begin
            mem_q[wr_ptr_q] <= {in_mode, ext_result};
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

endmodule

// File: tb/tb_extend_unit_pipe.sv
// Bench for extend_unit_pipe: directed literal checks on a DEPTH=2 instance plus a queue-based
// reference model compared every cycle against DEPTH=2 and DEPTH=4 instances fed the same stimulus.
`timescale 1ns/1ps
module tb_extend_unit_pipe;

   logic        clk = 1'b0;
   logic        reset, flush, in_valid, out_ready;
   logic [2:0]  in_mode;
   logic [15:0] in_data;

   logic        in_ready2, out_valid2, in_ready4, out_valid4;
   logic [31:0] out_data2, out_data4;
   logic [2:0]  out_mode2, out_mode4;
   logic [1:0]  count2;
   logic [2:0]  count4;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   logic [34:0] q2[$];
   logic [34:0] q4[$];

   always #5 clk = ~clk;

   extend_unit_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(2)) dut2 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready2),
      .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid2), .out_ready(out_ready),
      .out_data(out_data2), .out_mode(out_mode2), .count(count2)
   );

   extend_unit_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(4)) dut4 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
      .in_mode(in_mode), .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready),
      .out_data(out_data4), .out_mode(out_mode4), .count(count4)
   );

   // Reference extension from plain signed integer arithmetic.
   function automatic logic [31:0] ref_ext(input logic [2:0] m, input logic [15:0] d);
      longint s16, s8, v;
      s16 = d[15] ? longint'(d) - 65536 : longint'(d);
      s8  = d[7] ? longint'(d[7:0]) - 256 : longint'(d[7:0]);
      case (m)
         3'd0:    v = s16;
         3'd1:    v = longint'(d);
         3'd2:    v = longint'(d) * 65536;
         3'd3:    v = s16 * 4;
         3'd4:    v = s8;
         3'd5:    v = longint'(d[7:0]);
         3'd6:    v = s16;
         default: v = longint'(d);
      endcase
      return v[31:0];
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: FIFO semantics on SV queues, updated with the pre-edge input values.
   always @(posedge clk) begin
      if (reset || flush) begin
         q2.delete();
         q4.delete();
      end else begin
         bit pop2, push2, pop4, push4;
         pop2  = (q2.size() != 0) && out_ready;
         push2 = in_valid && (q2.size() < 2);
         pop4  = (q4.size() != 0) && out_ready;
         push4 = in_valid && (q4.size() < 4);
         if (pop2) void'(q2.pop_front());
         if (push2) q2.push_back({in_mode, ref_ext(in_mode, in_data)});
         if (pop4) void'(q4.pop_front());
         if (push4) q4.push_back({in_mode, ref_ext(in_mode, in_data)});
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         logic [34:0] h2, h4;
         h2 = (q2.size() != 0) ? q2[0] : 35'd0;
         h4 = (q4.size() != 0) ? q4[0] : 35'd0;
         check("d2_count", 64'(count2), 64'(q2.size()));
         check("d2_out_valid", 64'(out_valid2), 64'(q2.size() != 0));
         check("d2_in_ready", 64'(in_ready2), 64'(!reset && q2.size() < 2));
         check("d2_out_data", 64'(out_data2), 64'(h2[31:0]));
         check("d2_out_mode", 64'(out_mode2), 64'(h2[34:32]));
         check("d4_count", 64'(count4), 64'(q4.size()));
         check("d4_out_valid", 64'(out_valid4), 64'(q4.size() != 0));
         check("d4_in_ready", 64'(in_ready4), 64'(!reset && q4.size() < 4));
         check("d4_out_data", 64'(out_data4), 64'(h4[31:0]));
         check("d4_out_mode", 64'(out_mode4), 64'(h4[34:32]));
         check("d4_count_bound", 64'(count4 <= 3'd4), 64'd1);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [2:0]  t_mode [10];
      logic [15:0] t_data [10];
      logic [31:0] t_exp  [10];
      t_mode = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd4, 3'd5};
      t_data = '{16'h8004, 16'h8004, 16'h8004, 16'h8004, 16'h8004, 16'h8004, 16'h8004,
                 16'h8004, 16'h0080, 16'h0080};
      t_exp  = '{32'hFFFF8004, 32'h00008004, 32'h80040000, 32'hFFFE0010, 32'h00000004,
                 32'h00000004, 32'hFFFF8004, 32'h00008004, 32'hFFFFFF80, 32'h00000080};

      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_mode = 3'd0; in_data = 16'h0000;

      // Reset held for two cycles
      step();
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_in_ready_low", 64'(in_ready2), 64'd0);
      step();
      reset = 1'b0;
      @(negedge clk);
      check("rst_in_ready_high", 64'(in_ready2), 64'd1);
      check("rst_out_valid", 64'(out_valid2), 64'd0);
      check("rst_count", 64'(count2), 64'd0);
      check("rst_out_data", 64'(out_data2), 64'd0);

      // One request per mode with the consumer always ready
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_valid = 1'b1; in_mode = t_mode[i]; in_data = t_data[i];
         step();
         check($sformatf("mode%0d_data_%h", t_mode[i], t_data[i]), 64'(out_data2), 64'(t_exp[i]));
         check($sformatf("mode%0d_tag", t_mode[i]), 64'(out_mode2), 64'(t_mode[i]));
      end
      in_valid = 1'b0;
      step();
      check("drained_data_zero", 64'(out_data2), 64'd0);

      // Back-pressure: third request stalls, head held
      out_ready = 1'b0;
      in_valid = 1'b1; in_mode = 3'd0; in_data = 16'h1234;
      step();
      check("bp_count1", 64'(count2), 64'd1);
      in_mode = 3'd1; in_data = 16'hF000;
      step();
      check("bp_count2", 64'(count2), 64'd2);
      check("bp_in_ready", 64'(in_ready2), 64'd0);
      in_mode = 3'd2; in_data = 16'h00AB;
      step();
      check("bp_stall_count", 64'(count2), 64'd2);
      check("bp_head_stable", 64'(out_data2), 64'h0000_1234);

      // Full with both sides active: pop only, then push+pop
      out_ready = 1'b1;
      step();
      check("full_pop_count", 64'(count2), 64'd1);
      check("full_pop_head", 64'(out_data2), 64'h0000_F000);
      step();
      check("pushpop_count", 64'(count2), 64'd1);
      check("pushpop_head", 64'(out_data2), 64'h00AB_0000);
      in_valid = 1'b0;
      step();

      // Flush with two queued entries and a pending request
      out_ready = 1'b0; in_valid = 1'b1; in_mode = 3'd5; in_data = 16'h00FF;
      step();
      step();
      check("pre_flush_count", 64'(count2), 64'd2);
      flush = 1'b1;
      step();
      check("flush_count", 64'(count2), 64'd0);
      check("flush_out_valid", 64'(out_valid2), 64'd0);
      check("flush_out_data", 64'(out_data2), 64'd0);
      flush = 1'b0; in_valid = 1'b0;
      step();
      check("flush_input_dropped", 64'(count2), 64'd0);

      // Same with reset mid-stream
      in_valid = 1'b1; in_mode = 3'd3; in_data = 16'h7FFF;
      step();
      step();
      reset = 1'b1;
      step();
      check("midrst_count", 64'(count2), 64'd0);
      check("midrst_in_ready", 64'(in_ready2), 64'd0);
      reset = 1'b0; in_valid = 1'b0;
      step();
      check("midrst_after_count", 64'(count2), 64'd0);
      check("midrst_after_in_ready", 64'(in_ready2), 64'd1);

      // Random traffic; the per-cycle compare covers both depths
      for (int c = 0; c < 1000; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_mode   = 3'($urandom_range(0, 7));
         in_data   = 16'($urandom);
         flush     = ($urandom_range(0, 63) == 0);
         reset     = ($urandom_range(0, 127) == 0);
         step();
      end
      reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      step();
      step();
      @(negedge clk);
      chk_en = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
